// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking-network datapath:
// FSM encoding, row packing order and the saturating accumulate helper.
package snn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Widest accumulator the saturate helper supports (ACC_W must stay below it).
    localparam int MAX_W = 64;

    // Packed rows and accumulator vectors put channel 0 in the most significant slice.
    localparam bit CH0_IN_MSBS = 1'b1;

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned n_ch,
                                           input int unsigned w);
        if (CH0_IN_MSBS) begin
            return (n_ch - 32'd1 - ch) * w;
        end else begin
            return ch * w;
        end
    endfunction

    // Adds two sign-extended operands at MAX_W+1 bits and clamps to the acc_w-bit
    // signed range; returns {overflow, clamped value}.
    function automatic logic [MAX_W:0] sat_add(input logic signed [MAX_W-1:0] a,
                                               input logic signed [MAX_W-1:0] b,
                                               input int unsigned acc_w);
        logic signed [MAX_W:0] sum;
        logic signed [MAX_W:0] hi;
        logic signed [MAX_W:0] lo;
        logic                  ovf;
        sum = {a[MAX_W-1], a} + {b[MAX_W-1], b};
        hi  = '0;
        hi[acc_w - 32'd1] = 1'b1;
        hi  = hi - 65'sd1;
        lo  = ~hi;
        if (sum > hi) begin
            sum = hi;
            ovf = 1'b1;
        end else if (sum < lo) begin
            sum = lo;
            ovf = 1'b1;
        end else begin
            ovf = 1'b0;
        end
        return {ovf, sum[MAX_W-1:0]};
    endfunction

endpackage

// File: rtl/spike_row_accumulator_sat_acc.sv
// One signed saturating membrane accumulator channel with a sticky clamp flag.
// Clear has priority over enable; the spike bit drives the enable.
module sat_acc
    import snn_pkg::*;
#(
    parameter int W_W   = 16,
    parameter int ACC_W = 24
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    en_i,
    input  logic signed [W_W-1:0]   addend_i,
    output logic signed [ACC_W-1:0] acc_o,
    output logic                    sat_o
);

    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] acc_d;
    logic                    sat_q;
    logic                    sat_d;
    logic [MAX_W:0]          sum_res;
    logic                    unused_hi;

    assign sum_res   = sat_add(MAX_W'(acc_q), MAX_W'(addend_i), ACC_W);
    assign unused_hi = ^sum_res[MAX_W-1:ACC_W];

    // Next accumulator value and sticky saturation flag.
    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (clr_i) begin
            acc_d = '0;
            sat_d = 1'b0;
        end else if (en_i) begin
            acc_d = sum_res[ACC_W-1:0];
            sat_d = sat_q | sum_res[MAX_W];
        end else begin
            acc_d = acc_q;
            sat_d = sat_q;
        end
    end

    // Accumulator state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/spike_row_accumulator.sv
// Scans a latched spike vector one input per cycle, adding the weight row of every
// set spike into N_OUT saturating accumulators, then holds the row until taken.
module spike_row_accumulator
    import snn_pkg::*;
#(
    parameter int N_IN  = 8,
    parameter int N_OUT = 3,
    parameter int W_W   = 16,
    parameter int ACC_W = 24
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wt_we,
    input  logic [$clog2(N_IN)-1:0]  wt_addr,
    input  logic [N_OUT*W_W-1:0]     wt_row,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_IN-1:0]          in_spikes,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N_OUT*ACC_W-1:0]   out_acc,
    output logic [N_OUT-1:0]         out_sat
);

    localparam int IDX_W = $clog2(N_IN);

    state_e               state_q;
    logic [IDX_W-1:0]     idx_q;
    logic [N_IN-1:0]      spikes_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic signed [W_W-1:0] w_q [N_IN][N_OUT];

    logic accept;
    logic acc_en;
    logic last_idx;
    logic addr_ok;
    logic wt_ok;

    assign accept   = (state_q == ST_IDLE) && in_valid;
    assign acc_en   = (state_q == ST_SCAN) && spikes_q[idx_q];
    assign last_idx = (idx_q == IDX_W'(N_IN - 1));

    // Addresses past the last row only exist when N_IN is not a power of two.
    if ((2 ** IDX_W) > N_IN) begin : g_addr_chk
        assign addr_ok = (wt_addr <= IDX_W'(N_IN - 1));
    end else begin : g_addr_all
        assign addr_ok = 1'b1;
    end

    assign wt_ok = wt_we && (state_q == ST_IDLE) && addr_ok;

    // Control FSM with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            spikes_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        spikes_q   <= in_spikes;
                        idx_q      <= '0;
                        state_q    <= ST_SCAN;
                        in_ready_q <= 1'b0;
                    end
                end
                ST_SCAN: begin
                    idx_q <= idx_q + IDX_W'(1);
                    if (last_idx) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    idx_q       <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Weight matrix storage; reset clears every row.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N_IN; r++) begin
                for (int c = 0; c < N_OUT; c++) begin
                    w_q[r][c] <= '0;
                end
            end
        end else if (wt_ok) begin
            for (int c = 0; c < N_OUT; c++) begin
                w_q[wt_addr][c] <= wt_row[ch_lsb(c, N_OUT, W_W) +: W_W];
            end
        end
    end

    for (genvar c = 0; c < N_OUT; c++) begin : g_ch
        localparam int unsigned ACC_LSB = ch_lsb(c, N_OUT, ACC_W);
        localparam int unsigned SAT_BIT = ch_lsb(c, N_OUT, 1);

        sat_acc #(
            .W_W   (W_W),
            .ACC_W (ACC_W)
        ) u_acc (
            .clk      (clk),
            .rst      (rst),
            .clr_i    (accept),
            .en_i     (acc_en),
            .addend_i (w_q[idx_q][c]),
            .acc_o    (out_acc[ACC_LSB +: ACC_W]),
            .sat_o    (out_sat[SAT_BIT])
        );
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_spike_row_accumulator.sv
// Scoreboard bench for spike_row_accumulator: a 24-bit and a 16-bit accumulator
// instance share stimulus; expected rows come from a bench-side weight model.
module tb_spike_row_accumulator;

    localparam int N_IN  = 8;
    localparam int N_OUT = 3;
    localparam int W_W   = 16;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   wt_we;
    logic [2:0]             wt_addr;
    logic [N_OUT*W_W-1:0]   wt_row;
    logic                   in_valid;
    logic [N_IN-1:0]        in_spikes;
    logic                   out_ready;

    logic                   in_ready;
    logic                   out_valid;
    logic [N_OUT*24-1:0]    out_acc;
    logic [N_OUT-1:0]       out_sat;
    logic                   in_ready16;
    logic                   out_valid16;
    logic [N_OUT*16-1:0]    out_acc16;
    logic [N_OUT-1:0]       out_sat16;

    always #5 clk = ~clk;

    spike_row_accumulator #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .ACC_W(24)) u_dut (
        .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_row(wt_row),
        .in_valid(in_valid), .in_ready(in_ready), .in_spikes(in_spikes),
        .out_valid(out_valid), .out_ready(out_ready), .out_acc(out_acc), .out_sat(out_sat)
    );

    spike_row_accumulator #(.N_IN(N_IN), .N_OUT(N_OUT), .W_W(W_W), .ACC_W(16)) u_dut16 (
        .clk(clk), .rst(rst), .wt_we(wt_we), .wt_addr(wt_addr), .wt_row(wt_row),
        .in_valid(in_valid), .in_ready(in_ready16), .in_spikes(in_spikes),
        .out_valid(out_valid16), .out_ready(out_ready), .out_acc(out_acc16), .out_sat(out_sat16)
    );

    typedef struct packed {
        logic [N_OUT-1:0][63:0] e24;
        logic [N_OUT-1:0][63:0] e16;
        logic [N_OUT-1:0]       s24;
        logic [N_OUT-1:0]       s16;
        int                     acc_edge;
    } exp_t;

    exp_t   sb[$];
    longint w_m [N_IN][N_OUT];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_pass = 0;
    bit     seen_valid = 1'b0;
    bit     b2b_mode = 1'b0;
    int     last_acc = -1;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic longint get_ch(input logic [71:0] v, input int c, input int w);
        logic [71:0] t;
        longint      r;
        t = v >> ((N_OUT - 1 - c) * w);
        r = 0;
        for (int b = 0; b < 64; b++) begin
            r[b] = (b < w) ? t[b] : t[w-1];
        end
        return r;
    endfunction

    // Reference: clamp after every added row, exactly as a running accumulator would.
    function automatic longint model_ch(input logic [N_IN-1:0] sp, input int c, input int accw,
                                        output logic sat);
        longint mx, mn, r;
        mx  = (longint'(1) << (accw - 1)) - 1;
        mn  = -mx - 1;
        r   = 0;
        sat = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            if (sp[i]) begin
                r = r + w_m[i][c];
                if (r > mx) begin
                    r = mx;
                    sat = 1'b1;
                end else if (r < mn) begin
                    r = mn;
                    sat = 1'b1;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push on accept, check latency on first valid, pop and compare on handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                exp_t e;
                logic s;
                for (int c = 0; c < N_OUT; c++) begin
                    e.e24[c] = model_ch(in_spikes, c, 24, s);
                    e.s24[N_OUT-1-c] = s;
                    e.e16[c] = model_ch(in_spikes, c, 16, s);
                    e.s16[N_OUT-1-c] = s;
                end
                e.acc_edge = cyc + 1;
                sb.push_back(e);
                if (b2b_mode && last_acc >= 0) check_eq("accept_spacing", cyc + 1 - last_acc, N_IN + 2);
                last_acc = cyc + 1;
            end
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                if (sb.size() == 0) check_eq("spurious_valid", out_valid, 0);
                else check_eq("latency", cyc + 1 - sb[0].acc_edge, N_IN + 1);
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                seen_valid = 1'b0;
                check_eq("valid16", out_valid16, 1);
                for (int c = 0; c < N_OUT; c++) begin
                    check_eq($sformatf("acc24_ch%0d", c), get_ch(out_acc, c, 24), longint'(e.e24[c]));
                    check_eq($sformatf("acc16_ch%0d", c), get_ch({24'd0, out_acc16}, c, 16), longint'(e.e16[c]));
                end
                check_eq("sat24", out_sat, e.s24);
                check_eq("sat16", out_sat16, e.s16);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_row(input int addr, input int r0, input int r1, input int r2);
        wt_we   = 1'b1;
        wt_addr = 3'(addr);
        wt_row  = {16'(r0), 16'(r1), 16'(r2)};
        w_m[addr][0] = r0;
        w_m[addr][1] = r1;
        w_m[addr][2] = r2;
        tick(1);
        wt_we = 1'b0;
    endtask

    task automatic send(input logic [N_IN-1:0] sp);
        int n = 0;
        while (!in_ready && n < 50) begin
            tick(1);
            n++;
        end
        check_eq("ready_before_send", in_ready, 1);
        in_spikes = sp;
        in_valid  = 1'b1;
        tick(1);
        in_valid  = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick(1);
            n++;
        end
        check_eq("drain", sb.size(), 0);
    endtask

    task automatic check_idle_reset(input string tag);
        check_eq({tag, "_in_ready"}, in_ready, 1);
        check_eq({tag, "_out_valid"}, out_valid, 0);
        check_eq({tag, "_out_acc"}, (out_acc == '0) ? 1 : 0, 1);
        check_eq({tag, "_out_sat"}, out_sat, 0);
        check_eq({tag, "_out_acc16"}, (out_acc16 == '0) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [71:0] held;
        int n;
        rst = 1'b1; wt_we = 1'b0; wt_addr = '0; wt_row = '0;
        in_valid = 1'b0; in_spikes = '0; out_ready = 1'b1;
        for (int i = 0; i < N_IN; i++) for (int c = 0; c < N_OUT; c++) w_m[i][c] = 0;
        tick(3);
        rst = 1'b0;
        check_idle_reset("reset");

        // Rows i = {1,2,3}*(i+1), then three spike patterns.
        for (int i = 0; i < N_IN; i++) write_row(i, i + 1, 2 * (i + 1), 3 * (i + 1));
        send(8'b0000_0101);
        wait_done();
        send(8'h00);
        wait_done();
        send(8'hFF);
        wait_done();

        // Hold out_ready low in DONE while ignored weight writes are attempted.
        out_ready = 1'b0;
        send(8'h03);
        n = 0;
        while (!out_valid && n < 30) begin
            tick(1);
            n++;
        end
        check_eq("hold_reached_done", out_valid, 1);
        held = out_acc;
        for (int k = 0; k < 5; k++) begin
            wt_we = 1'b1; wt_addr = 3'(3 + k); wt_row = {N_OUT*W_W{1'b1}};
            tick(1);
            check_eq("hold_valid", out_valid, 1);
            check_eq("hold_in_ready", in_ready, 0);
            for (int c = 0; c < N_OUT; c++) check_eq("hold_acc", get_ch(out_acc, c, 24), get_ch(held, c, 24));
        end
        wt_we = 1'b0;
        out_ready = 1'b1;
        wait_done();
        send(8'hF8);
        wait_done();

        // Saturation; row 7 is written on the same edge as the accept.
        for (int i = 0; i < N_IN - 1; i++) write_row(i, 32767, -32768, -1);
        wt_we = 1'b1; wt_addr = 3'd7; wt_row = {16'sh7FFF, 16'sh8000, 16'shFFFF};
        w_m[7][0] = 32767; w_m[7][1] = -32768; w_m[7][2] = -1;
        in_spikes = 8'hFF; in_valid = 1'b1;
        tick(1);
        wt_we = 1'b0; in_valid = 1'b0;
        wait_done();

        // Reset on the 4th scan edge discards the result and clears weights.
        send(8'h01);
        tick(3);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        sb.delete();
        seen_valid = 1'b0;
        for (int i = 0; i < N_IN; i++) for (int c = 0; c < N_OUT; c++) w_m[i][c] = 0;
        check_idle_reset("midscan_reset");
        send(8'h01);
        wait_done();

        // Back-to-back with random weights and spikes.
        for (int i = 0; i < N_IN; i++)
            write_row(i, int'($urandom_range(2000)) - 1000, int'($urandom_range(2000)) - 1000,
                      int'($urandom_range(2000)) - 1000);
        b2b_mode = 1'b1;
        last_acc = -1;
        in_valid = 1'b1;
        for (int k = 0; k < 45; k++) begin
            in_spikes = N_IN'($urandom);
            tick(1);
        end
        in_valid = 1'b0;
        b2b_mode = 1'b0;
        wait_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/spike_row_accumulator.md
# spike_row_accumulator

Sequential, parametrised successor to the spike-gated weight row multiplier. It holds an N_IN × N_OUT signed weight matrix. It accepts one binary spike vector per transaction and scans the vector one input per cycle. For each set spike, it adds the corresponding weight row into N_OUT saturating membrane accumulators, then presents the accumulated row. It sits between the spike encoder and the neuron threshold/fire stage of the SNN datapath.

## Interface
- N_IN, 8: number of spike inputs (rows of the weight matrix), ≥2
- N_OUT, 3: number of output channels (columns), ≥1
- W_W, 16: signed weight width
- ACC_W, 24: signed accumulator width, ≥ W_W
- clk  in  1  single clock, all logic rising-edge
- rst  in  1  reset, synchronous and active-high
- wt_we  in  1  weight row write strobe
- wt_addr  in  $clog2(N_IN)  row index to write
- wt_row  in  N_OUT*W_W  signed row; channel 0 in MSBs
- in_valid  in  1  spike vector valid
- in_ready  out  1  block can accept a spike vector
- in_spikes  in  N_IN  bit i = spike on input i
- out_valid  out  1  accumulated row valid
- out_ready  in  1  downstream accepts the row
- out_acc  out  N_OUT*ACC_W  signed accumulators; channel 0 in MSBs
- out_sat  out  N_OUT  sticky per-channel saturation flag for this transaction

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch in_spikes, clear all accumulators and out_sat, set idx = 0, go to SCAN.
- SCAN:
  - Each cycle, if spike[idx] = 1, acc[c] <= sat(acc[c] + sext(w[idx][c])) for every c; if spike[idx] = 0, hold.
  - idx increments each cycle.
  - After idx = N_IN-1 is processed, go to DONE.
- DONE:
  - out_valid = 1; out_acc and out_sat are stable.
  - On out_ready, go to IDLE. out_acc keeps its value until the next accept.
- Saturation:
  - The sum is computed at ACC_W+1 bits.
  - Positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
  - Either clamp sets out_sat[c], which stays set until the next accept.
- Weight writes:
  - Accepted only in IDLE; written on the clock edge and visible to the next transaction.
  - wt_we in SCAN or DONE is ignored with no effect.
  - wt_addr ≥ N_IN is ignored.
- in_valid outside IDLE is not accepted; in_ready = 0 there.

## Timing
- Reset values: state IDLE; in_ready 1; out_valid 0; out_acc 0; out_sat 0; all weights 0; idx 0.
- Accept at edge k → SCAN during cycles k+1 … k+N_IN → out_valid high from cycle k+N_IN+1. Latency is N_IN+1 cycles regardless of spike pattern.
- out_valid holds until out_ready is sampled high. in_ready rises the cycle after the out handshake, so throughput is one vector per N_IN+2 cycles minimum.
- out_ready high on the first DONE cycle is legal: one DONE cycle.
- rst during SCAN or DONE: next cycle is the reset state, the partial result is discarded, and weights are cleared.
- Same-edge wt_we and accept in IDLE: the write lands, and the row is used by this transaction only if the scan reaches it afterwards. Because the write completes at the accept edge, all rows read in SCAN reflect it.

## Structure
- Package snn_pkg holds:
  - the FSM state encoding (IDLE/SCAN/DONE);
  - a sign-extend/saturate function parametrised by ACC_W;
  - the row-packing convention constant (channel 0 = MSBs).
- Sub-module sat_acc: one signed saturating accumulator channel (clear, enable, addend, acc, sat flag).
  - Instantiated N_OUT times via generate.
  - The spike bit acts as the enable, generalising the old per-weight gate.

## Test plan
- Reset, then write rows 0..7 = {1,2,3}·(i+1); send spikes 8'b0000_0101 → out_acc = {4,8,12}, out_sat = 0, out_valid exactly 9 cycles after accept.
- Spikes 8'h00 → out_acc = {0,0,0}, same 9-cycle latency; spikes 8'hFF with the same weights → {36,72,108}.
- ACC_W=16: all rows = {16'sh7FFF, -16'sh8000, -1}; spikes 8'hFF → out_acc = {32767, -32768, -8}, out_sat = 3'b110.
- Hold out_ready low 5 cycles in DONE → out_valid and out_acc stable, in_ready 0; wt_we pulses meanwhile leave weights unchanged in the next transaction.
- Assert rst at the 4th SCAN cycle → next cycle in_ready 1, out_valid 0, out_acc 0; a rerun with spikes 8'h01 yields {0,0,0} because weights were cleared.
- Back-to-back: in_valid held high with out_ready high → accepts spaced exactly N_IN+2 = 10 cycles; each result matches a reference model of sum over set spikes of w[i].
